// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller and the datapath it drives.
package multicycle_ctrl_pkg;

    // FSM state codes; 12-15 are unused and recover to StFetch.
    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJEx     = 4'd11
    } state_e;

    // Opcodes
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    // R-type funct codes
    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;

    // Main-FSM to ALU-decoder operation class
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    // ALU function select
    localparam logic [2:0] AluCtlAnd = 3'b000;
    localparam logic [2:0] AluCtlOr  = 3'b001;
    localparam logic [2:0] AluCtlAdd = 3'b010;
    localparam logic [2:0] AluCtlSub = 3'b110;
    localparam logic [2:0] AluCtlSlt = 3'b111;

    // ALU B operand select
    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    // Next-PC select
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: maps the FSM operation class and R-type funct to an ALU function.
module alu_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Fixed add/sub for memory and branch ops, funct decode for R-type
    always_comb begin
        alucontrol = AluCtlAdd;
        case (aluop)
            AluOpAdd: alucontrol = AluCtlAdd;
            AluOpSub: alucontrol = AluCtlSub;
            AluOpFunct: begin
                case (funct)
                    FunctAdd: alucontrol = AluCtlAdd;
                    FunctSub: alucontrol = AluCtlSub;
                    FunctAnd: alucontrol = AluCtlAnd;
                    FunctOr:  alucontrol = AluCtlOr;
                    FunctSlt: alucontrol = AluCtlSlt;
                    default:  alucontrol = AluCtlAdd;
                endcase
            end
            default: alucontrol = AluCtlAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore controller for a multicycle MIPS-subset datapath (lw, sw, R-type, beq, addi, j).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned OPW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic [OPW-1:0] funct,
    input  logic           zero,
    output logic           pcen,
    output logic           irwrite,
    output logic           memwrite,
    output logic           regwrite,
    output logic           iord,
    output logic           alusrca,
    output logic           regdst,
    output logic           memtoreg,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic [2:0]     alucontrol,
    output logic [3:0]     state
);

    state_e     state_q, state_d;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;

    // State register; reset lands in FETCH without waiting for a clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: op only steers DECODE and MEMADR
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRtypeEx;
                    OpBeq:      state_d = StBeqEx;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJEx;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (op == OpLw) ? StMemRd : StMemWr;
            StMemRd:   state_d = StMemWb;
            StRtypeEx: state_d = StRtypeWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
    end

    // Output decode from state; strobes are suppressed while reset is held
    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        alusrca  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrcb  = SrcBReg;
        pcsrc    = PcSrcAlu;
        aluop    = AluOpAdd;
        case (state_q)
            StFetch: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = SrcBFour;
            end
            StDecode: alusrcb = SrcBImmSh;
            StMemAdr, StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = SrcBImm;
            end
            StMemRd: iord = 1'b1;
            StMemWb: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            StRtypeEx: begin
                alusrca = 1'b1;
                aluop   = AluOpFunct;
            end
            StRtypeWb: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            StBeqEx: begin
                alusrca = 1'b1;
                aluop   = AluOpSub;
                pcsrc   = PcSrcAluOut;
                branch  = 1'b1;
            end
            StAddiWb: regwrite = 1'b1;
            StJEx: begin
                pcsrc   = PcSrcJump;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pcwrite  = 1'b0;
            branch   = 1'b0;
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
        end
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

    alu_dec u_alu_dec (
        .aluop      (aluop),
        .funct      (funct[5:0]),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: instruction-path model compared every cycle plus directed literal checks.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'b111111;
    logic [5:0] funct = 6'b100000;
    logic       zero = 1'b0;

    logic       pcen, irwrite, memwrite, regwrite;
    logic       iord, alusrca, regdst, memtoreg;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl #(.OPW(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .alusrca    (alusrca),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // Each instruction is a path of states: {len, s4, s3, s2, s1, s0}, nibble k = k-th state.
    function automatic logic [23:0] path_of(input logic [5:0] o);
        case (o)
            6'b100011: return 24'h543210;  // lw
            6'b101011: return 24'h405210;  // sw
            6'b000000: return 24'h407610;  // R-type
            6'b001000: return 24'h40A910;  // addi
            6'b000100: return 24'h300810;  // beq
            6'b000010: return 24'h300B10;  // j
            default:   return 24'h200010;  // unsupported
        endcase
    endfunction

    function automatic logic [2:0] alu_fn(input logic [1:0] aop, input logic [5:0] fn);
        if (aop == 2'b01) return 3'b110;
        if (aop != 2'b10) return 3'b010;
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [18:0] model_out(input logic [3:0] st, input logic rst,
                                              input logic [5:0] fn, input logic z);
        logic pcw, br, irw, mw, rw, io, asa, rdst, m2r;
        logic [1:0] srcb, pcs, aop;
        {pcw, br, irw, mw, rw, io, asa, rdst, m2r} = '0;
        srcb = 2'b00;
        pcs  = 2'b00;
        aop  = 2'b00;
        case (st)
            4'd0:  begin irw = 1; pcw = 1; srcb = 2'b01; end
            4'd1:  srcb = 2'b11;
            4'd2, 4'd9: begin asa = 1; srcb = 2'b10; end
            4'd3:  io = 1;
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin io = 1; mw = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rdst = 1; rw = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
            4'd10: rw = 1;
            4'd11: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (rst) {pcw, br, irw, mw, rw} = '0;
        return {st, pcw | (br & z), irw, mw, rw, io, asa, rdst, m2r, srcb, pcs, alu_fn(aop, fn)};
    endfunction

    int          k;
    logic [23:0] path_q;
    logic [23:0] cur_path;
    logic [3:0]  exp_state;

    assign cur_path = path_of(op);

    // Step index along the current instruction's path; path is chosen leaving DECODE.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k      <= 0;
            path_q <= 24'h200010;
        end else if (k == 1) begin
            path_q <= cur_path;
            k      <= (cur_path[23:20] > 4'd2) ? 2 : 0;
        end else begin
            k      <= (k + 1 >= int'(path_q[23:20])) ? 0 : k + 1;
        end
    end

    always_comb exp_state = (k < 2) ? 4'(k) : path_q[4*k +: 4];

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        check("cycle outputs",
              {state, pcen, irwrite, memwrite, regwrite, iord, alusrca, regdst, memtoreg,
               alusrcb, pcsrc, alucontrol},
              model_out(exp_state, reset, funct, zero));
    end

    int rw_total = 0;
    always @(negedge clk) rw_total <= rw_total + int'(regwrite);

    // ---------------- directed ----------------
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int len, input logic [23:0] exp_trace,
                             input int exp_rw, input int exp_mw,
                             output logic [2:0] ctl6, output logic [2:0] br8);
        logic [23:0] trace;
        int rw, mw;
        op = o;
        funct = f;
        zero = z;
        trace = '0;
        rw = 0;
        mw = 0;
        ctl6 = 'x;
        br8 = 'x;
        check({name, " start"}, state, 0);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            trace = {trace[19:0], state};
            rw += int'(regwrite);
            mw += int'(memwrite);
            if (state == 4'd6) ctl6 = alucontrol;
            if (state == 4'd8) br8 = {pcen, pcsrc};
            if (state == 4'd4) check({name, " memtoreg"}, {regwrite, memtoreg}, 2'b11);
            @(posedge clk);
            #2;
        end
        check({name, " trace"}, trace, exp_trace);
        check({name, " end"}, state, 0);
        check({name, " regwrite"}, rw, exp_rw);
        check({name, " memwrite"}, mw, exp_mw);
    endtask

    logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    logic [2:0] ctl_tab [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

    initial begin
        logic [2:0] c6, b8;
        int snap;
        #1 reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset state", state, 0);
            check("reset strobes", {pcen, irwrite, regwrite}, 3'b000);
        end
        @(posedge clk);
        #2 reset = 1'b0;

        run_instr("bad op", 6'b111111, 6'b100000, 1'b0, 2, 24'h01, 0, 0, c6, b8);
        run_instr("lw", 6'b100011, 6'b100000, 1'b0, 5, 24'h01234, 1, 0, c6, b8);
        run_instr("sw", 6'b101011, 6'b100000, 1'b0, 4, 24'h0125, 0, 1, c6, b8);
        for (int i = 0; i < 6; i++) begin
            run_instr("rtype", 6'b000000, fn_tab[i], 1'b0, 4, 24'h0167, 1, 0, c6, b8);
            check("rtype alucontrol", c6, ctl_tab[i]);
        end
        run_instr("addi", 6'b001000, 6'b100000, 1'b0, 4, 24'h019A, 1, 0, c6, b8);
        run_instr("beq taken", 6'b000100, 6'b100000, 1'b1, 3, 24'h018, 0, 0, c6, b8);
        check("beq taken pcen/pcsrc", b8, 3'b101);
        run_instr("beq not taken", 6'b000100, 6'b100000, 1'b0, 3, 24'h018, 0, 0, c6, b8);
        check("beq not taken pcen/pcsrc", b8, 3'b001);
        run_instr("j", 6'b000010, 6'b100000, 1'b0, 3, 24'h01B, 0, 0, c6, b8);

        // Reset in the middle of a load, while in MEMRD
        op = 6'b100011;
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        check("lw at MEMRD", state, 3);
        snap = rw_total;
        #1 reset = 1'b1;
        #1 check("async reset state", state, 0);
        check("async reset strobes", {pcen, irwrite, memwrite, regwrite}, 4'b0000);
        check("async reset muxes", {iord, alusrca, regdst, memtoreg, alusrcb, pcsrc, alucontrol},
              12'b0000_01_00_010);
        op = 6'b111111;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        check("after reset release", state, 0);
        @(posedge clk);
        #2 check("first edge after reset", state, 1);
        repeat (4) @(posedge clk);
        #2 check("aborted lw regwrite", rw_total, snap);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
